// File: rtl/dist_ram_pkg.sv
// Shared types and defaults for the distributed RAM with byte enables and a clear sweep.
// DIST_RAM_OUT_REG_EN (top level) selects a registered read port.
package dist_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_BYTE_W = 8;
  localparam int DEF_ADDR_W = 6;

  function automatic int num_lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/dist_ram_clr_seq.sv
// Clear sequencer: walks every address once after reset or a clr request,
// reporting busy and producing the sweep address and write strobe.
module dist_ram_clr_seq
  import dist_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  // No sweep write lands while reset is held; the sweep restarts at 0 afterwards.
  assign sweep_we   = busy & ~rst;
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/dist_ram_sp_be_clr.sv
// Single-port LUT RAM, async read, per-byte write enables, hardware clear sweep.
// Define DIST_RAM_OUT_REG_EN for a registered read port (one-cycle latency, resets to 0).
module dist_ram_sp_be_clr
  import dist_ram_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                BYTE_W    = DEF_BYTE_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       we,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          a,
  input  logic [DATA_W-1:0]          di,
  output logic [DATA_W-1:0]          dout,
  output logic                       busy
);

  localparam int LANES = num_lanes(DATA_W, BYTE_W);
  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (DATA_W % BYTE_W != 0) begin : g_bad_width
      $error("DATA_W must be a multiple of BYTE_W");
    end
  endgenerate

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  dist_ram_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .busy      (busy),
    .sweep_addr(sweep_addr),
    .sweep_we  (sweep_we)
  );

  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

  logic [LANES-1:0]  wr_lane_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Sweep owns the array; a clr in the same cycle drops the user write.
  always_comb begin
    wr_addr    = a;
    wr_data    = di;
    wr_lane_en = '0;
    if (sweep_we) begin
      wr_addr    = sweep_addr;
      wr_data    = CLEAR_VAL;
      wr_lane_en = '1;
    end else if (we && !busy && !clr && !rst) begin
      wr_lane_en = be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane_en[i]) begin
        mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef DIST_RAM_OUT_REG_EN
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = mem[a];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  assign dout = mem[a];
`endif

endmodule

// File: tb/tb_dist_ram_sp_be_clr.sv
// Directed plus randomized bench for dist_ram_sp_be_clr against an array-based reference model.
module tb_dist_ram_sp_be_clr;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int LANES  = 2;
  localparam logic [DATA_W-1:0] CLEAR_VAL = 16'h0000;

  logic              clk = 1'b0;
  logic              rst, clr, we;
  logic [LANES-1:0]  be;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] di, dout;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  dist_ram_sp_be_clr #(
    .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be),
    .a(a), .di(di), .dout(dout), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLEAR_VAL;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input logic [LANES-1:0] lanes);
    for (int i = 0; i < LANES; i++)
      if (lanes[i]) ref_mem[addr][i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [LANES-1:0] lanes);
    @(negedge clk);
    we = 1'b1; a = addr; di = data; be = lanes;
    @(negedge clk);
    we = 1'b0;
    model_write(addr, data, lanes);
  endtask

  task automatic read_chk(input logic [ADDR_W-1:0] addr, input string tag);
    @(negedge clk);
    we = 1'b0; clr = 1'b0; a = addr;
`ifdef DIST_RAM_OUT_REG_EN
    @(negedge clk);
`endif
    #1;
    check(tag, {16'h0, dout}, {16'h0, ref_mem[addr]});
  endtask

  // Counts sampled cycles with busy high, starting at the current negedge; bounded at 200.
  task automatic measure_busy(output int n, input int inject_at);
    n = 0;
    while (n < 200) begin
      #1;
      if (!busy) break;
      if (n == inject_at) begin
        we = 1'b1; a = 6'd3; di = 16'hFFFF; be = 2'b11;
      end else begin
        we = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  initial begin
    int n;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic [LANES-1:0]  rb;

    rst = 1'b1; clr = 1'b0; we = 1'b0; be = '0; a = '0; di = '0;

    // Reset sweep with a blocked write injected at sweep cycle 10
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {31'h0, busy}, 32'd1);
    rst = 1'b0;
    measure_busy(n, 10);
    check("reset_sweep_len", n, DEPTH);
    model_clear();
    for (int i = 0; i < DEPTH; i++) read_chk(i[ADDR_W-1:0], $sformatf("sweep_rd_%0d", i));
    read_chk(6'd3, "blocked_wr");
    check("blocked_wr_const", {16'h0, dout}, {16'h0, CLEAR_VAL});

    // Byte-lane write; same-cycle read must still show the old word
    do_write(6'd5, 16'hABCD, 2'b11);
    @(negedge clk);
    we = 1'b1; a = 6'd5; di = 16'h1234; be = 2'b01;
    #1;
`ifndef DIST_RAM_OUT_REG_EN
    check("byte_wr_same_cycle", {16'h0, dout}, 32'h0000ABCD);
`endif
    @(negedge clk);
    we = 1'b0;
    model_write(6'd5, 16'h1234, 2'b01);
    #1;
`ifdef DIST_RAM_OUT_REG_EN
    check("rdw_old_data", {16'h0, dout}, 32'h0000ABCD);
    @(negedge clk);
    #1;
`endif
    check("byte_wr_merge", {16'h0, dout}, 32'h0000AB34);
    do_write(6'd5, 16'h7777, 2'b00);
    read_chk(6'd5, "be_zero_noop");

    // clr beats a same-cycle write
    do_write(6'd7, 16'h5555, 2'b11);
    read_chk(6'd7, "pre_clr");
    @(negedge clk);
    clr = 1'b1; we = 1'b1; a = 6'd7; di = 16'h9999; be = 2'b11;
    @(negedge clk);
    clr = 1'b0; we = 1'b0;
    measure_busy(n, -1);
    check("clr_sweep_len", n, DEPTH);
    model_clear();
    read_chk(6'd7, "clr_over_wr");
    read_chk(6'd5, "clr_wiped");

    // Reset in the middle of a clr sweep restarts it
    do_write(6'd20, 16'hBEEF, 2'b11);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset_busy", {31'h0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    measure_busy(n, -1);
    check("mid_reset_sweep_len", n, DEPTH - 1);
    model_clear();
    read_chk(6'd20, "mid_reset_clear");

    // Random writes and reads in IDLE
    for (int k = 0; k < 200; k++) begin
      ra = 6'($urandom_range(0, DEPTH - 1));
      rd = 16'($urandom);
      rb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) do_write(ra, rd, rb);
      if ($urandom_range(0, 1) != 0) read_chk(ra, "rand_rd_same");
      else read_chk(6'($urandom_range(0, DEPTH - 1)), "rand_rd_any");
    end

`ifdef DIST_RAM_OUT_REG_EN
    do_write(6'd9, 16'h0F0F, 2'b11);
    read_chk(6'd9, "regout_rd");
    @(negedge clk);
    a = 6'd9; rst = 1'b1;
    @(negedge clk);
    #1;
    check("regout_rst_zero", {16'h0, dout}, 32'h0);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist_ram_sp_be_clr.md
Name: dist_ram_sp_be_clr

Overview:
Parametrised single-port distributed RAM with asynchronous read, per-byte write enables and a hardware clear sequencer. After reset, or on request, the sequencer fills every location with CLEAR_VAL. Intended as the general-purpose LUT-RAM for small register files and lookup tables. Implementation must infer distributed RAM, not block RAM.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of BYTE_W (elaboration error otherwise)
BYTE_W, 8, write-enable lane width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W
CLEAR_VAL, 0, DATA_W-bit value written to every word during a clear sweep

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  single-cycle clear request
we  in  1  write enable
be  in  DATA_W/BYTE_W  byte-lane enables; lane i covers di[i*BYTE_W +: BYTE_W]
a  in  ADDR_W  read/write address
di  in  DATA_W  write data
dout  out  DATA_W  read data
busy  out  1  clear sweep in progress; user writes ignored

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Write: on the clk edge with we=1, busy=0 and clr=0, lanes with be[i]=1 update ram[a]. Other lanes keep their old value. we=1 with be all-zero is a no-op.
- Read: dout = ram[a], combinational with zero latency. A write appears on dout after the clock edge that performs it; there is no write-through bypass within the cycle.
- FSM states: CLEAR and IDLE. Clear counter cnt is ADDR_W bits.
- rst=1:
  - State becomes CLEAR, cnt becomes 0, busy becomes 1.
  - Memory is not written while rst=1.
  - Reset mid-sweep restarts the sweep at address 0.
- CLEAR:
  - Each cycle with rst=0 writes CLEAR_VAL to ram[cnt] (all lanes), then cnt increments.
  - When cnt = DEPTH-1 is written, the next state is IDLE and busy falls.
  - busy is high for exactly DEPTH cycles after rst deasserts.
  - User writes and clr are ignored during CLEAR.
- IDLE:
  - clr=1 moves to CLEAR with cnt=0; busy=1 from the next cycle for DEPTH cycles.
  - clr has priority over a same-cycle user write, which is dropped.
- dout during CLEAR still reflects ram[a], so it may show a mix of old data and CLEAR_VAL. Consumers must gate reads on busy=0.
- Reset values: busy=1, state=CLEAR, cnt=0. dout is not reset (memory content) unless OUT_REG_EN is defined.
- cnt wrap: cnt wraps to 0 at the end of the sweep and is don't-care in IDLE.

Optional Feature:
DIST_RAM_OUT_REG_EN
- Defined:
  - dout is registered: dout(t+1) = ram[a](t), giving one-cycle read latency.
  - The register resets to 0 on rst and holds CLEAR_VAL-consistent data once the sweep ends.
  - Read-during-write returns old data.
- Undefined: asynchronous read as above.

Decomposition:
- Package dist_ram_pkg:
  - state enum (CLEAR, IDLE)
  - function num_lanes(DATA_W, BYTE_W)
  - default parameter constants
- One natural sub-module, dist_ram_clr_seq:
  - contains the FSM and counter
  - outputs busy, the sweep address and the sweep write strobe
  - top-level muxes sweep versus user address, data and enables into the array

Test Plan:
- Reset sweep: DATA_W=16, ADDR_W=6, rst high for 3 cycles, then low → busy high for exactly 64 cycles. Then reading a=0..63 returns 0x0000 everywhere.
- Byte write: write a=5, di=0xABCD, be=2'b11, then a=5, di=0x1234, be=2'b01 → dout=0xAB34 at a=5 in the cycle after the second write (same-cycle dout still 0xABCD).
- Writes blocked: we=1, a=3, di=0xFFFF during the sweep at cycle 10 → after busy falls, a=3 reads CLEAR_VAL.
- clr vs write: in IDLE, with ram[7]=0x5555, assert clr and we (a=7, di=0x9999) in the same cycle → busy high for 64 cycles, and ram[7] ends as CLEAR_VAL.
- Reset mid-sweep: clr, then rst at sweep cycle 30 → the sweep restarts and busy is high for 64 cycles after rst drops.
- DIST_RAM_OUT_REG_EN defined: write a=9, di=0x0F0F; next cycle set a=9 → dout=0x0F0F one cycle later and still old data in the presenting cycle. rst forces dout=0.
